// File: rtl/decoder_2_to_4_dfl_pkg.sv
// Shared types and constants for the 2-to-4 decoder slice.
// Address and one-hot line encodings used by the core and the top.
package decoder_2_to_4_dfl_pkg;

  typedef logic [1:0] addr_t;
  typedef logic [3:0] line_t;

  localparam line_t LINE_NONE = 4'b0000;
  localparam line_t LINE_D0   = 4'b0001;
  localparam line_t LINE_D1   = 4'b0010;
  localparam line_t LINE_D2   = 4'b0100;
  localparam line_t LINE_D3   = 4'b1000;

endpackage

// File: rtl/decoder_2_to_4_dfl_core.sv
// Pure combinational 2-to-4 one-hot decode with enable.
// Enable gates the address so X on the address cannot leak when idle.
module dec2to4_core
  import decoder_2_to_4_dfl_pkg::*;
(
  input  logic  en,
  input  addr_t a,
  output line_t line
);

  always_comb begin
    line = LINE_NONE;
    if (en) begin
      unique case (1'b1)
        (a == 2'd0): line = LINE_D0;
        (a == 2'd1): line = LINE_D1;
        (a == 2'd2): line = LINE_D2;
        (a == 2'd3): line = LINE_D3;
        default:     line = LINE_NONE;
      endcase
    end
  end

endmodule

// File: rtl/decoder_2_to_4_dfl.sv
// 2-to-4 decoder with optional output register, selectable polarity
// and a register holding the address of the last enabled decode.
module decoder_2_to_4_dfl
  import decoder_2_to_4_dfl_pkg::*;
#(
  parameter bit REGISTERED     = 1'b0,
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  input  logic       A1,
  input  logic       A0,
  output logic       D0,
  output logic       D1,
  output logic       D2,
  output logic       D3,
  output logic       any_active,
  output logic [1:0] last_code
);

  addr_t addr;
  line_t dec_line;
  line_t out_line;
  line_t pin_line;

  assign addr = {A1, A0};

  dec2to4_core u_core (
    .en  (EN),
    .a   (addr),
    .line(dec_line)
  );

  generate
    if (REGISTERED) begin : g_reg
      line_t line_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) line_q <= LINE_NONE;
        else     line_q <= dec_line;
      end
      assign out_line = line_q;
    end else begin : g_comb
      assign out_line = dec_line;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     last_code <= 2'b00;
    else if (EN) last_code <= addr;
  end

  // Polarity applies to the pins only; any_active stays logical.
  assign any_active = |out_line;
  assign pin_line   = OUT_ACTIVE_LOW ? ~out_line : out_line;
  assign {D3, D2, D1, D0} = pin_line;

endmodule

// File: tb/tb_decoder_2_to_4_dfl.sv
// Scoreboard bench: four parameter variants driven in lockstep,
// expectations from a cycle-level reference model.
module tb_decoder_2_to_4_dfl;

  typedef struct {
    logic [3:0] d_comb;
    logic [3:0] d_reg;
    logic [1:0] lc;
  } exp_t;

  logic clk = 1'b0;
  logic rst, en, a1, a0;
  logic [3:0][3:0] dq;
  logic [3:0]      anyv;
  logic [3:0][1:0] lcv;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_dut
    decoder_2_to_4_dfl #(
      .REGISTERED    ((i % 2) == 1),
      .OUT_ACTIVE_LOW((i / 2) == 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .EN        (en),
      .A1        (a1),
      .A0        (a0),
      .D0        (dq[i][0]),
      .D1        (dq[i][1]),
      .D2        (dq[i][2]),
      .D3        (dq[i][3]),
      .any_active(anyv[i]),
      .last_code (lcv[i])
    );
  end

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: outputs are stable by the falling edge of each cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [3:0] d;
      e = sb.pop_front();
      for (int i = 0; i < 4; i++) begin
        d = (i % 2 == 1) ? e.d_reg : e.d_comb;
        chk($sformatf("u%0d.D", i), dq[i],
            (i / 2 == 1) ? ~d : d);
        chk($sformatf("u%0d.any", i), {3'b0, anyv[i]},
            {3'b0, d != 4'b0});
        chk($sformatf("u%0d.last_code", i), {2'b0, lcv[i]},
            {2'b0, e.lc});
      end
    end
  end

  // Reference model state.
  logic       p_rst = 1'b1;
  logic       p_en  = 1'b0;
  logic [1:0] p_a   = 2'b00;
  logic [1:0] m_lc  = 2'b00;
  logic [3:0] m_rq  = 4'b0000;

  task automatic step(input logic r, input logic e,
                      input logic [1:0] a, input bit ax);
    exp_t x;
    @(posedge clk);
    if (p_rst) begin
      m_lc = 2'b00;
      m_rq = 4'b0000;
    end else begin
      if (p_en) m_lc = p_a;
      m_rq = p_en ? (4'b0001 << p_a) : 4'b0000;
    end
    #1;
    rst = r;
    en  = e;
    if (ax) begin
      a1 = 1'bx;
      a0 = 1'bx;
    end else begin
      a1 = a[1];
      a0 = a[0];
    end
    if (r) begin
      m_lc = 2'b00;
      m_rq = 4'b0000;
    end
    x.d_comb = e ? (4'b0001 << a) : 4'b0000;
    x.d_reg  = m_rq;
    x.lc     = m_lc;
    sb.push_back(x);
    p_rst = r;
    p_en  = e;
    p_a   = a;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    a1  = 1'b0;
    a0  = 1'b0;
    step(1, 0, 2'd0, 1);
    step(0, 0, 2'd0, 1);
    for (int k = 0; k < 4; k++) step(0, 1, 2'(k), 0);
    step(0, 1, 2'd3, 0);
    step(0, 0, 2'd0, 0);
    step(0, 0, 2'd1, 0);
    step(0, 1, 2'd2, 0);
    step(0, 1, 2'd2, 0);
    step(1, 1, 2'd2, 0);
    step(0, 1, 2'd2, 0);
    step(0, 1, 2'd2, 0);
    step(0, 1, 2'd1, 0);
    step(0, 0, 2'd1, 0);
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), 0);
    end
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decoder_2_to_4_dfl.md
DECODER_2_TO_4_DFL -- requirements
Module: decoder_2_to_4_dfl

Interface
REQ-001 The block SHALL have one clock, `clk`; reset `rst` SHALL be asynchronous and active-high.
REQ-002 Parameter `REGISTERED`, default 0, SHALL select the output path: 0 = combinational decode, 1 = decode registered on `clk`.
REQ-003 Parameter `OUT_ACTIVE_LOW`, default 0, SHALL select output polarity: 0 = selected line high, 1 = selected line low, others high.
REQ-004 Port `clk`, input, 1 bit, SHALL be the clock for all registered state.
REQ-005 Port `rst`, input, 1 bit, SHALL be the asynchronous active-high reset.
REQ-006 Port `EN`, input, 1 bit, SHALL be the decoder enable.
REQ-007 Port `A1`, input, 1 bit, SHALL be the address MSB.
REQ-008 Port `A0`, input, 1 bit, SHALL be the address LSB.
REQ-009 Ports `D0`, `D1`, `D2`, `D3`, each output, 1 bit, SHALL be the decoded lines for address 0 to 3.
REQ-010 Port `any_active`, output, 1 bit, SHALL be high when any decoded line is asserted (logical sense).
REQ-011 Port `last_code`, output, 2 bits, SHALL hold the address {A1,A0} of the most recent enabled decode.

Function
REQ-012 With EN=0, all four lines SHALL be deasserted (0000 for D3..D0 when OUT_ACTIVE_LOW=0), whatever the values on A1/A0, including X.
REQ-013 With EN=1, exactly one line SHALL be asserted: index = {A1,A0}, so 00→D0, 01→D1, 10→D2, 11→D3.
REQ-014 Asserted lines SHALL be one-hot, and more than one asserted line SHALL never occur.
REQ-015 When REGISTERED=0, D0–D3 and any_active SHALL follow the inputs with zero cycles of latency and no dependence on `clk`.
REQ-016 When REGISTERED=1, D0–D3 and any_active SHALL update on the rising edge of `clk` and show the decode of the inputs sampled at that edge (1-cycle latency).
REQ-017 `last_code` SHALL load {A1,A0} on each rising edge where EN=1 and SHALL hold its value while EN=0.
REQ-018 `OUT_ACTIVE_LOW` SHALL invert only D0–D3, and SHALL NOT invert any_active or last_code.
REQ-019 If the inputs change in the same cycle as a clock edge (REGISTERED=1), the value sampled at the edge SHALL determine the registered output.

Reset
REQ-020 While `rst`=1, all registered state SHALL clear immediately, without waiting for a clock edge: last_code=00, and the registered D lines and any_active go deasserted.
REQ-021 In REGISTERED=0 mode, reset SHALL NOT affect D0–D3 or any_active, which stay purely combinational.
REQ-022 Reset asserted in the middle of operation SHALL override the decode, and the first edge after `rst` falls SHALL resume normal sampling.

Structure
REQ-023 A shared package SHALL hold the 2-bit address type and the 4-bit one-hot line type, together with the constants LINE_NONE=4'b0000 and LINE_D0..LINE_D3.
REQ-024 The combinational decode SHALL be one sub-module, `dec2to4_core` (EN and A in, 4-bit one-hot out), and the top SHALL add the registering, polarity and last_code logic around it.

Verification
REQ-025 The bench SHALL drive EN=0, A1=X, A0=X and require D3..D0=0000 and any_active=0.
REQ-026 The bench SHALL drive EN=1 with {A1,A0}=00,01,10,11 in turn and require D3..D0=0001,0010,0100,1000, with any_active=1 each time.
REQ-027 The bench SHALL run REGISTERED=1 with EN=1, {A1,A0}=10 applied before an edge, and require D3..D0=0100 only after that edge, not before.
REQ-028 The bench SHALL drive EN=1, {A1,A0}=11, take a clock edge, then set EN=0 and take two edges, and require last_code=11 to be held.
REQ-029 The bench SHALL assert rst between clock edges (REGISTERED=1, D2 active) and require all lines and last_code at 0 at once, with 0100 returning on the first edge after release.
REQ-030 The bench SHALL run OUT_ACTIVE_LOW=1 with EN=1, {A1,A0}=01 and require D3..D0=1101; with EN=0 it SHALL require 1111.
